rs_regfile_multi: RTL and testbench

Parametrised architectural register file with per-register rename status (busy bit + ROB tag) for the out-of-order core. It sits between decode/issue and the reservation stations, and generalises the single-port register status file. It supports N in-order commit ports from the ROB, two issue-read pairs with same-cycle commit forwarding, and a pipeline flush that drops all in-flight renames. It also maintains a live count of renamed registers for issue throttling.

---
 rtl/rs_regfile_multi.sv | 115 +++++++++++
 tb/tb_rs_regfile_multi.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_regfile_multi.sv
// rtl/rs_regfile_multi.sv - register file with rename status, multi-port commit, flush and busy count
module rs_regfile_multi #(
  parameter int WIDTH   = 32,
  parameter int NREG    = 32,
  parameter int TAG_W   = 4,
  parameter int NCOMMIT = 2,
  localparam int IDX_W  = $clog2(NREG),
  localparam int CNT_W  = $clog2(NREG) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NCOMMIT-1:0]         commit_valid,
  input  logic [NCOMMIT*TAG_W-1:0]   commit_tag,
  input  logic [NCOMMIT*WIDTH-1:0]   commit_data,
  input  logic                       issue_valid,
  input  logic [IDX_W-1:0]           issue_rd,
  input  logic [TAG_W-1:0]           issue_tag,
  input  logic [IDX_W-1:0]           rs1_idx,
  input  logic [IDX_W-1:0]           rs2_idx,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [WIDTH-1:0]           rs1_val,
  output logic [WIDTH-1:0]           rs2_val,
  output logic [CNT_W-1:0]           busy_count
);

  logic [WIDTH-1:0] data_q [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [NREG-1:0]  busy_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] data_d [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];
  logic [NREG-1:0]  busy_d;
  logic [CNT_W-1:0] count_d;

  // Operand lookup: pending renames resolve from a matching commit port in the same cycle;
  // the loop runs upward so the highest matching port wins.
  function automatic logic [WIDTH:0] read_src(input logic [IDX_W-1:0] idx);
    logic             b;
    logic [WIDTH-1:0] v;
    b = 1'b0;
    v = '0;
    if (idx != '0) begin
      if (busy_q[idx]) begin
        b = 1'b1;
        v = WIDTH'(tag_q[idx]);
        for (int p = 0; p < NCOMMIT; p++) begin
          if (commit_valid[p] && (commit_tag[p*TAG_W +: TAG_W] == tag_q[idx])) begin
            b = 1'b0;
            v = commit_data[p*WIDTH +: WIDTH];
          end
        end
      end else begin
        v = data_q[idx];
      end
    end
    return {b, v};
  endfunction

  // Combinational source reads from pre-update state plus commit forwarding
  always_comb begin
    {rs1_busy, rs1_val} = read_src(rs1_idx);
    {rs2_busy, rs2_val} = read_src(rs2_idx);
  end

  // Next-state: commits first, then flush or issue on top; issue keeps the commit's data write
  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    count_d = '0;
    for (int i = 1; i < NREG; i++) begin
      for (int p = 0; p < NCOMMIT; p++) begin
        if (commit_valid[p] && busy_q[i] && (tag_q[i] == commit_tag[p*TAG_W +: TAG_W])) begin
          data_d[i] = commit_data[p*WIDTH +: WIDTH];
          busy_d[i] = 1'b0;
        end
      end
    end
    if (flush) begin
      busy_d = '0;
    end else if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_tag;
    end
    busy_d[0] = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      count_d = count_d + CNT_W'(busy_d[i]);
    end
  end

  // State registers with asynchronous clear; x0 stays at its reset value forever
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_count = count_q;

endmodule

// File: tb/tb_rs_regfile_multi.sv
// tb/tb_rs_regfile_multi.sv - directed self-checking bench for rs_regfile_multi
module tb_rs_regfile_multi;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  commit_valid;
  logic [7:0]  commit_tag;
  logic [63:0] commit_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_tag;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [5:0]  busy_count;

  int checks;
  int failures;

  rs_regfile_multi dut (
    .clk(clk), .rst(rst), .flush(flush),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_data(commit_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .busy_count(busy_count)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush        = 1'b0;
    commit_valid = 2'b00;
    issue_valid  = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    idle();
    commit_tag = '0;
    commit_data = '0;
    issue_rd = '0;
    issue_tag = '0;
    rs1_idx = 5'd5;
    rs2_idx = 5'd0;
    #3;
    check("reset_busy", 32'(rs1_busy), 32'd0);
    check("reset_val", rs1_val, 32'd0);
    check("reset_count", 32'(busy_count), 32'd0);
    #10;
    rst = 1'b0;
    tick();

    // rename x5 to tag 3
    issue_valid = 1'b1; issue_rd = 5'd5; issue_tag = 4'd3;
    tick();
    idle();
    #1;
    check("ren_busy", 32'(rs1_busy), 32'd1);
    check("ren_val", rs1_val, 32'd3);
    check("ren_count", 32'(busy_count), 32'd1);

    // commit tag 3 with forwarding
    commit_valid = 2'b01; commit_tag = {4'd0, 4'd3}; commit_data = {32'd0, 32'hDEAD};
    #1;
    check("fwd_busy", 32'(rs1_busy), 32'd0);
    check("fwd_val", rs1_val, 32'hDEAD);
    tick();
    idle();
    #1;
    check("cmt_busy", 32'(rs1_busy), 32'd0);
    check("cmt_val", rs1_val, 32'hDEAD);
    check("cmt_count", 32'(busy_count), 32'd0);

    // stale commit on re-renamed x7
    issue_valid = 1'b1; issue_rd = 5'd7; issue_tag = 4'd1;
    tick();
    issue_tag = 4'd2;
    tick();
    idle();
    rs1_idx = 5'd7;
    check("stale_count", 32'(busy_count), 32'd1);
    commit_valid = 2'b01; commit_tag = {4'd0, 4'd1}; commit_data = {32'd0, 32'h11};
    #1;
    check("stale_fwd_busy", 32'(rs1_busy), 32'd1);
    check("stale_fwd_val", rs1_val, 32'd2);
    tick();
    idle();
    #1;
    check("stale_busy", 32'(rs1_busy), 32'd1);
    check("stale_val", rs1_val, 32'd2);
    commit_valid = 2'b01; commit_tag = {4'd0, 4'd2}; commit_data = {32'd0, 32'h22};
    tick();
    idle();
    #1;
    check("x7_val", rs1_val, 32'h22);
    check("x7_count", 32'(busy_count), 32'd0);

    // dual commit
    issue_valid = 1'b1; issue_rd = 5'd3; issue_tag = 4'd4;
    tick();
    issue_rd = 5'd9; issue_tag = 4'd6;
    tick();
    idle();
    check("dual_pre_count", 32'(busy_count), 32'd2);
    commit_valid = 2'b11; commit_tag = {4'd6, 4'd4}; commit_data = {32'hB, 32'hA};
    tick();
    idle();
    rs1_idx = 5'd3; rs2_idx = 5'd9;
    #1;
    check("dual_x3", rs1_val, 32'hA);
    check("dual_x9", rs2_val, 32'hB);
    check("dual_x9_busy", 32'(rs2_busy), 32'd0);
    check("dual_count", 32'(busy_count), 32'd0);

    // flush with a same-cycle issue
    issue_valid = 1'b1; issue_rd = 5'd1; issue_tag = 4'd7;
    tick();
    issue_rd = 5'd2; issue_tag = 4'd8;
    tick();
    issue_rd = 5'd4; issue_tag = 4'd9;
    tick();
    check("flush_pre_count", 32'(busy_count), 32'd3);
    flush = 1'b1; issue_rd = 5'd8; issue_tag = 4'd10;
    rs1_idx = 5'd1;
    #1;
    check("flush_read_busy", 32'(rs1_busy), 32'd1);
    check("flush_read_val", rs1_val, 32'd7);
    tick();
    idle();
    rs1_idx = 5'd8; rs2_idx = 5'd3;
    #1;
    check("flush_count", 32'(busy_count), 32'd0);
    check("flush_x8_busy", 32'(rs1_busy), 32'd0);
    check("flush_x3_val", rs2_val, 32'hA);

    // issue to x0 is ignored
    issue_valid = 1'b1; issue_rd = 5'd0; issue_tag = 4'd1;
    tick();
    idle();
    rs1_idx = 5'd0;
    #1;
    check("x0_count", 32'(busy_count), 32'd0);
    check("x0_busy", 32'(rs1_busy), 32'd0);
    check("x0_val", rs1_val, 32'd0);

    // issue and commit collide on x6
    issue_valid = 1'b1; issue_rd = 5'd6; issue_tag = 4'd11;
    tick();
    check("coll_pre_count", 32'(busy_count), 32'd1);
    issue_tag = 4'd5;
    commit_valid = 2'b01; commit_tag = {4'd0, 4'd11}; commit_data = {32'd0, 32'h55};
    rs1_idx = 5'd6;
    #1;
    check("coll_fwd_val", rs1_val, 32'h55);
    tick();
    idle();
    #1;
    check("coll_busy", 32'(rs1_busy), 32'd1);
    check("coll_tag", rs1_val, 32'd5);
    check("coll_count", 32'(busy_count), 32'd1);
    flush = 1'b1;
    tick();
    idle();
    #1;
    check("coll_data", rs1_val, 32'h55);
    check("coll_flush_count", 32'(busy_count), 32'd0);

    // both ports match one register: port 1 wins
    issue_valid = 1'b1; issue_rd = 5'd10; issue_tag = 4'd12;
    tick();
    idle();
    commit_valid = 2'b11; commit_tag = {4'd12, 4'd12}; commit_data = {32'h2, 32'h1};
    rs1_idx = 5'd10;
    #1;
    check("prio_fwd", rs1_val, 32'h2);
    tick();
    idle();
    #1;
    check("prio_val", rs1_val, 32'h2);

    // asynchronous reset mid-stream
    issue_valid = 1'b1; issue_rd = 5'd11; issue_tag = 4'd13;
    tick();
    idle();
    check("arst_pre_count", 32'(busy_count), 32'd1);
    #2;
    rst = 1'b1;
    rs1_idx = 5'd11; rs2_idx = 5'd3;
    #1;
    check("arst_count", 32'(busy_count), 32'd0);
    check("arst_busy", 32'(rs1_busy), 32'd0);
    check("arst_val", rs1_val, 32'd0);
    check("arst_x3", rs2_val, 32'd0);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
